// File: rtl/key_scan_ctrl.sv
// POKEY keyboard scan sequencer: two-phase enables, scan strobe divider, SKCTL bits and key/break IRQ front-end.
// Optional overrun flag is built only when KEY_OVERRUN_EN is defined.
module key_scan_ctrl #(
   parameter int SCAN_DIV = 114,
   parameter int DIV_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       skctlWr,
   input  logic [1:0] skctlDin,
   input  logic       irqEnWr,
   input  logic [1:0] irqEnDin,
   input  logic [1:0] irqAck,
   input  logic       stResWr,
   input  logic       setKey,
   input  logic       setBreak,
   output logic       enp,
   output logic       enn,
   output logic       keybClk,
   output logic [1:0] SKCTLS,
   output logic [1:0] irqPend,
   output logic       nIrq,
   output logic       kbOverrun
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic             ph_reg;
   logic             reset_d_reg;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_next;
   logic             keyb_reg;
   logic             keyb_next;
   logic [1:0]       skctl_reg;
   logic [1:0]       irq_en_reg;
   logic [1:0]       pend_reg;
   logic [1:0]       pend_next;
   logic [1:0]       evin_d_reg;
   logic [1:0]       ev;
   logic             scan_en_next;
   logic             scan_start;
   logic             div_wrap;

   // ph is held at 0 through the first clock after reset so enp leads.
   always_ff @(posedge clk) begin
      reset_d_reg <= reset;
      if (reset || reset_d_reg) begin
         ph_reg <= 1'b0;
      end else begin
         ph_reg <= ~ph_reg;
      end
   end

   assign enp = ~ph_reg & ~reset_d_reg;
   assign enn = ph_reg;

   assign scan_en_next = skctlWr ? skctlDin[1] : skctl_reg[1];
   assign scan_start   = skctlWr & skctlDin[1] & ~skctl_reg[1];
   assign div_wrap     = enn & (div_reg == DIV_LAST);

   always_comb begin
      div_next = div_reg;
      if (!scan_en_next || scan_start) begin
         div_next = '0;
      end else if (enn) begin
         div_next = div_wrap ? '0 : div_reg + 1'b1;
      end
   end

   // Strobe rises on the wrap edge and survives exactly one enp clock.
   assign keyb_next = scan_en_next & ~scan_start & (div_wrap | (keyb_reg & enp));

   always_ff @(posedge clk) begin
      if (reset) begin
         div_reg    <= '0;
         keyb_reg   <= 1'b0;
         skctl_reg  <= 2'b00;
         irq_en_reg <= 2'b00;
         pend_reg   <= 2'b00;
         evin_d_reg <= 2'b00;
      end else begin
         div_reg    <= div_next;
         keyb_reg   <= keyb_next;
         pend_reg   <= pend_next;
         evin_d_reg <= {setBreak, setKey};
         if (skctlWr) begin
            skctl_reg <= skctlDin;
         end
         if (irqEnWr) begin
            irq_en_reg <= irqEnDin;
         end
      end
   end

   assign ev = {setBreak, setKey} & ~evin_d_reg;

   // Priority per bit: disable-write clear, then enabled event, then ack.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_pend
         assign pend_next[gi] = (irqEnWr && !irqEnDin[gi]) ? 1'b0 :
                                (ev[gi] && irq_en_reg[gi]) ? 1'b1 :
                                irqAck[gi]                 ? 1'b0 :
                                pend_reg[gi];
      end
   endgenerate

`ifdef KEY_OVERRUN_EN
   logic ovr_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         ovr_reg <= 1'b0;
      end else if (ev[0] && pend_reg[0] && !irqAck[0]) begin
         ovr_reg <= 1'b1;
      end else if (stResWr) begin
         ovr_reg <= 1'b0;
      end
   end

   assign kbOverrun = ovr_reg;
`else
   logic unused_st_res;

   assign unused_st_res = stResWr;
   assign kbOverrun     = 1'b0;
`endif

   assign keybClk = keyb_reg;
   assign SKCTLS  = skctl_reg;
   assign irqPend = pend_reg;
   assign nIrq    = ~|pend_reg;

endmodule

// File: doc/key_scan_ctrl.md
# key_scan_ctrl

Sequencer and interrupt front-end for the POKEY keyboard scan block. It generates the two-phase enables (`enp`/`enn`) and the periodic keyboard scan strobe (`keybClk`), and holds the SKCTL scan-mode bits (`SKCTLS`) that drive the scan core. It turns the core's `setKey`/`setBreak` pulses into latched, maskable interrupt requests with a CPU acknowledge path and an overrun flag. It sits between the CPU register decode and the keyboard scan core.

## Interface
- `SCAN_DIV`, 114: `enn` phases per keyboard scan strobe period; legal range 2..255.
- `DIV_W`, 8: width of the strobe divider counter; must hold `SCAN_DIV-1`.

- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `skctlWr` in 1: write strobe for `skctlDin`.
- `skctlDin` in 2: new SKCTLS value. Bit 1 is scan enable; bit 0 is debounce enable.
- `irqEnWr` in 1: write strobe for `irqEnDin`.
- `irqEnDin` in 2: interrupt enables. Bit 0 is key; bit 1 is break.
- `irqAck` in 2: one-cycle clear of the matching pending bits.
- `stResWr` in 1: clears `kbOverrun`.
- `setKey` in 1: key-code-loaded pulse from the scan core.
- `setBreak` in 1: break pulse from the scan core.
- `enp` out 1: positive-phase enable.
- `enn` out 1: negative-phase enable.
- `keybClk` out 1: scan strobe to the core.
- `SKCTLS` out 2: registered SKCTL scan bits to the core.
- `irqPend` out 2: pending interrupts. Bit 0 is key; bit 1 is break.
- `nIrq` out 1: active-low interrupt request, equal to `~|irqPend`, combinational.
- `kbOverrun` out 1: a key code arrived while a key IRQ was still pending.

## Operation
- **Phase generator.**
  - 1-bit `ph` register toggles every clock.
  - `enp = ~ph & ~reset_d`, `enn = ph`.
  - `enp` and `enn` are never high together and alternate with strict 1:1 spacing.
- **Strobe divider.**
  - Counter `div` advances on `enn` cycles only.
  - It counts `0..SCAN_DIV-1`, then wraps to 0.
  - `keybClk` goes high on the cycle after `div` wraps to 0 and stays high for exactly 2 clocks: one `enp` cycle, then one `enn` cycle.
- **Scan disable.**
  - While `SKCTLS[1]==0`, `div` is held at 0 and `keybClk` is forced low.
  - Writing `SKCTLS[1]` from 0 to 1 restarts the divider from 0. The first strobe occurs `SCAN_DIV` `enn` cycles later.
  - Writing `SKCTLS[1]` from 1 to 0 while `keybClk` is high drops `keybClk` on the next clock.
- **SKCTL register.** On `skctlWr`, `SKCTLS <= skctlDin` on the next edge.
- **IRQ enable register.**
  - On `irqEnWr`, `irqEn <= irqEnDin`.
  - Any bit written 0 also clears the matching `irqPend` bit in the same edge.
- **Pending bits.**
  - `setKey` and `setBreak` are rising-edge detected against a registered copy. Each is typically high for 2 clocks; exactly one event is counted per pulse.
  - An event sets its `irqPend` bit only if the corresponding `irqEn` bit is 1.
  - `irqAck[n]` clears `irqPend[n]`.
  - Simultaneous event and ack on the same bit: the set wins.
  - Simultaneous event and `irqEnWr` that disables the same bit: the clear wins.
- **Overrun.**
  - A `setKey` rising edge while `irqPend[0]==1` and not acked in the same cycle sets `kbOverrun`.
  - `kbOverrun` is cleared only by `stResWr` or `reset`. If set and `stResWr` coincide, the set wins.

## Timing
- **Reset values (all outputs):** `ph=0`, `enp=0`, `enn=0`, `div=0`, `keybClk=0`, `SKCTLS=2'b00`, `irqEn=2'b00`, `irqPend=2'b00`, `nIrq=1`, `kbOverrun=0`, edge-detect registers=0.
- **Reset release:** on the first clock after `reset` deasserts, `enp=1`; the next clock gives `enn=1`. `reset_d` is a 1-cycle delayed copy of `reset`.
- **Reset mid-operation:** aborts any strobe in progress next edge and clears all pending and overrun state.
- **Write and event latency:**
  - Register writes take effect on outputs 1 clock after the strobe.
  - Event to `irqPend`: 1 clock after the rising edge of `setKey`/`setBreak`.
  - Event to `nIrq`: same cycle as `irqPend`, since `nIrq` is combinational.
- **Strobe period:** `2*SCAN_DIV` clocks; `keybClk` duty is 2 clocks.

## Configuration
- `KEY_OVERRUN_EN`
  - **Defined:** the overrun detection logic and the `stResWr` clear are built.
  - **Undefined:** `kbOverrun` is tied to 0, `stResWr` is ignored, and no overrun register exists.

## Test plan
- **Reset and phase:** assert `reset` 3 clocks, release. Required: `enp=1` on clock 1 after release, `enn=1` on clock 2, alternating thereafter; all other outputs at their reset values.
- **Scan strobe:** `SCAN_DIV=4`, write `skctlDin=2'b10`. Required: `keybClk` high for 2 clocks every 8 clocks, first rise 8 clocks after the `SKCTLS` update. Then write `2'b00` mid-strobe. Required: `keybClk` low next clock and stays low.
- **Key IRQ:** `irqEn=2'b01`, pulse `setKey` for 2 clocks. Required: `irqPend=2'b01` and `nIrq=0` after 1 clock, single event. `irqAck=2'b01`. Required: `irqPend=0`, `nIrq=1`.
- **Masking:** `irqEn=2'b01`, pulse `setBreak`. Required: `irqPend` unchanged. Set `irqEn=2'b11` with break pending, then write `irqEn=2'b01`. Required: `irqPend[1]` cleared.
- **Collision:** `setKey` rising edge on the same clock as `irqAck[0]`. Required: `irqPend[0]=1`, `kbOverrun=0`.
- **Overrun:** `KEY_OVERRUN_EN` defined, two `setKey` pulses with no ack. Required: `kbOverrun=1`; `stResWr` clears it. With the macro undefined, the same stimulus leaves `kbOverrun=0`.
